// File: rtl/rr_burst_pop_arbiter_if.sv
// Pop/select handshake between the arbitrated FIFOs and the round-robin burst pop arbiter.
// The FIFO side uses the master modport; the arbiter uses the slave modport.
interface rr_burst_pop_arbiter_if #(
    parameter int NUM_FIFOS = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) ();
    logic [NUM_FIFOS-1:0] empty;
    logic [NUM_FIFOS-1:0] en_mask;
    logic                 ready;
    logic [NUM_FIFOS-1:0] gnt;
    logic [TAGWIDTH-1:0]  gnt_sel;
    logic                 gnt_vld;

    modport master (
        output empty, en_mask, ready,
        input  gnt, gnt_sel, gnt_vld
    );

    modport slave (
        input  empty, en_mask, ready,
        output gnt, gnt_sel, gnt_vld
    );
endinterface

// File: rtl/rr_burst_pop_arbiter.sv
// Round-robin pop arbiter with bursts: one owner may take up to BURST back-to-back pops,
// then priority rotates starting just past the last owner. Grants are same-cycle and gated by ready.
module rr_burst_pop_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int BURST     = 2,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_burst_pop_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [TAGWIDTH-1:0]  last, last_n;
    logic [NUM_FIFOS-1:0] req;
    logic [TAGWIDTH-1:0]  pick;
    logic [TAGWIDTH-1:0]  cand;
    logic                 pick_vld;

    assign req = ~bus.empty & bus.en_mask;

    // The owner keeps priority until its burst is spent; otherwise scan from last+1, last scanned last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        if (state == S_BURST && req[last] && cnt < BURST_C) begin
            pick     = last;
            pick_vld = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_FIFOS; k++) begin
                cand = TAGWIDTH'((int'(last) + k) % NUM_FIFOS);
                if (!pick_vld && req[cand]) begin
                    pick     = cand;
                    pick_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.gnt     = '0;
        bus.gnt_sel = '0;
        bus.gnt_vld = 1'b0;
        if (rst && bus.ready && pick_vld) begin
            bus.gnt[pick] = 1'b1;
            bus.gnt_sel   = pick;
            bus.gnt_vld   = 1'b1;
        end
    end

    // A ready cycle with no requester at all releases the lock; ready=0 freezes everything.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        if (bus.ready) begin
            if (pick_vld) begin
                if (state == S_BURST && pick == last && cnt < BURST_C) begin
                    cnt_n = cnt + CW'(1);
                end else begin
                    cnt_n   = CW'(1);
                    last_n  = pick;
                    state_n = S_BURST;
                end
            end else begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            last  <= TAGWIDTH'(NUM_FIFOS - 1);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

`ifdef FORMAL
    always_comb begin
        if (rst) begin
            assert ($onehot0(bus.gnt));
            assert ((bus.gnt & ~(req & {NUM_FIFOS{bus.ready}})) == '0);
            assert (bus.gnt_vld == |bus.gnt);
            assert (!bus.gnt_vld || bus.gnt[bus.gnt_sel]);
            assert (cnt <= BURST_C);
            assert ((cnt == '0) == (state == S_IDLE));
        end
    end
`endif
endmodule

// File: tb/tb_rr_burst_pop_arbiter.sv
// Directed and randomized checks of rr_burst_pop_arbiter against a grant-order reference model.
module tb_rr_burst_pop_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_burst_pop_arbiter_if #(.NUM_FIFOS(N)) bus_a ();
    rr_burst_pop_arbiter_if #(.NUM_FIFOS(N)) bus_b ();

    rr_burst_pop_arbiter #(.NUM_FIFOS(N), .BURST(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    rr_burst_pop_arbiter #(.NUM_FIFOS(N), .BURST(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owned the most recent grant and how many pops its current run has used.
    int m_last;
    int m_run;

    function automatic int m_pick(input logic [N-1:0] req, input bit rdy, input int burst);
        if (!rdy || req == '0) return -1;
        if (m_run > 0 && req[m_last] && m_run < burst) return m_last;
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic m_commit(input int o, input bit rdy, input int burst);
        if (!rdy) return;
        if (o < 0) m_run = 0;
        else if (m_run > 0 && o == m_last && m_run < burst) m_run++;
        else begin
            m_run  = 1;
            m_last = o;
        end
    endtask

    task automatic m_reset();
        m_last = N - 1;
        m_run  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after a posedge, check outputs at negedge, check state after next posedge.
    task automatic step(input logic [N-1:0] e, input logic [N-1:0] en, input bit rdy,
                        input bit use_b, input int burst, input string tag, output int sel_obs);
        int o;
        logic [N-1:0] g;
        logic [31:0]  s;
        logic         v;
        if (use_b) begin
            bus_b.empty = e; bus_b.en_mask = en; bus_b.ready = rdy;
        end else begin
            bus_a.empty = e; bus_a.en_mask = en; bus_a.ready = rdy;
        end
        o = m_pick(~e & en, rdy, burst);
        @(negedge clk);
        g = use_b ? bus_b.gnt : bus_a.gnt;
        s = use_b ? 32'(bus_b.gnt_sel) : 32'(bus_a.gnt_sel);
        v = use_b ? bus_b.gnt_vld : bus_a.gnt_vld;
        check({tag, ".gnt"}, 32'(g), (o < 0) ? 32'd0 : (32'd1 << o));
        check({tag, ".gnt_sel"}, s, (o < 0) ? 32'd0 : 32'(o));
        check({tag, ".gnt_vld"}, 32'(v), (o < 0) ? 32'd0 : 32'd1);
        sel_obs = int'(s);
        @(posedge clk);
        #1;
        m_commit(o, rdy, burst);
        check({tag, ".cnt"}, use_b ? 32'(dut_b.cnt) : 32'(dut_a.cnt), 32'(m_run));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        int t1 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int t2 [5] = '{1, 2, 1, 2, 1};
        int t6 [6] = '{0, 1, 3, 0, 1, 3};
        logic [N-1:0] re, ren;
        bit rr;

        bus_a.empty = '1; bus_a.en_mask = '1; bus_a.ready = 1'b1;
        bus_b.empty = '1; bus_b.en_mask = '1; bus_b.ready = 1'b0;
        m_reset();

        // Reset holds outputs low even with requests and ready present.
        bus_a.empty = '0;
        @(negedge clk);
        check("rst.gnt", 32'(bus_a.gnt), 32'd0);
        check("rst.gnt_vld", 32'(bus_a.gnt_vld), 32'd0);
        check("rst.gnt_sel", 32'(bus_a.gnt_sel), 32'd0);
        check("rst.cnt", 32'(dut_a.cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: full rotation with bursts of two
        for (int i = 0; i < 9; i++) begin
            step(4'b0000, 4'b1111, 1'b1, 1'b0, 2, "t1", sel);
            check("t1.order", 32'(sel), 32'(t1[i]));
        end

        // 2: sole requester FIFO2 restarts its burst
        for (int i = 0; i < 5; i++) begin
            step(4'b1011, 4'b1111, 1'b1, 1'b0, 2, "t2", sel);
            check("t2.sel", 32'(sel), 32'd2);
            check("t2.cnt_seq", 32'(dut_a.cnt), 32'(t2[i]));
        end

        // 3: one grant to FIFO1, stall, then resume the burst
        step(4'b1101, 4'b1111, 1'b1, 1'b0, 2, "t3.own", sel);
        check("t3.first", 32'(sel), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b1111, 1'b0, 1'b0, 2, "t3.stall", sel);
            check("t3.hold_cnt", 32'(dut_a.cnt), 32'd1);
        end
        step(4'b0000, 4'b1111, 1'b1, 1'b0, 2, "t3.resume", sel);
        check("t3.resume_sel", 32'(sel), 32'd1);
        step(4'b0000, 4'b1111, 1'b1, 1'b0, 2, "t3.rotate", sel);
        check("t3.rotate_sel", 32'(sel), 32'd2);

        // 4: owner FIFO1 empties mid-burst
        step(4'b1101, 4'b1111, 1'b1, 1'b0, 2, "t4.own", sel);
        check("t4.own_sel", 32'(sel), 32'd1);
        step(4'b0110, 4'b1111, 1'b1, 1'b0, 2, "t4.a", sel);
        check("t4.a_sel", 32'(sel), 32'd3);
        check("t4.a_cnt", 32'(dut_a.cnt), 32'd1);
        step(4'b0110, 4'b1111, 1'b1, 1'b0, 2, "t4.b", sel);
        step(4'b0110, 4'b1111, 1'b1, 1'b0, 2, "t4.c", sel);
        check("t4.c_sel", 32'(sel), 32'd0);

        // No requester with ready releases the lock; en_mask drop mid-burst moves on
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 2, "idle", sel);
        check("idle.cnt", 32'(dut_a.cnt), 32'd0);
        step(4'b0000, 4'b1111, 1'b1, 1'b0, 2, "mask.a", sel);
        step(4'b0000, 4'b1101, 1'b1, 1'b0, 2, "mask.b", sel);

        // 5: async reset mid-burst on FIFO3
        step(4'b0111, 4'b1111, 1'b1, 1'b0, 2, "t5.own", sel);
        check("t5.own_sel", 32'(sel), 32'd3);
        bus_a.empty = 4'b0000; bus_a.en_mask = 4'b1111; bus_a.ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("t5.async_gnt", 32'(bus_a.gnt), 32'd0);
        check("t5.async_vld", 32'(bus_a.gnt_vld), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        step(4'b0000, 4'b1111, 1'b1, 1'b0, 2, "t5.after", sel);
        check("t5.after_sel", 32'(sel), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            re  = N'($urandom);
            ren = N'($urandom | $urandom);
            rr  = ($urandom % 4) != 0;
            step(re, ren, rr, 1'b0, 2, "rand", sel);
        end
        bus_a.ready = 1'b0;

        // 6: BURST=1 instance, FIFO2 masked off
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b0000, 4'b1011, 1'b1, 1'b1, 1, "t6", sel);
            check("t6.order", 32'(sel), 32'(t6[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
